// File: rtl/bit_serializer_pkg.sv
// Shared types for the bit serializer feeding the 101-sequence detector.
package bit_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/bit_serializer.sv
// Double-buffered parallel-to-serial converter: MSB-first, one bit per clock,
// fixed idle bit between words, valid/ready input handshake.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             word_start,
   output logic             busy
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   ser_state_t       r_state, w_state;
   logic [WIDTH-1:0] r_sr, w_sr;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [WIDTH-1:0] r_hold, w_hold;
   logic             r_hold_full, w_hold_full;
   logic             w_word_start;
   logic             w_xfer;
   logic             r_x, r_x_valid, r_word_start;

   assign w_xfer = in_valid & ~r_hold_full;

   always_comb begin
      w_state      = r_state;
      w_sr         = r_sr;
      w_cnt        = r_cnt;
      w_hold       = r_hold;
      w_hold_full  = r_hold_full;
      w_word_start = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_xfer) begin
               w_sr         = in_data;
               w_cnt        = CNT_LAST;
               w_state      = SHIFT;
               w_word_start = 1'b1;
            end
         end
         SHIFT: begin
            if (r_cnt == '0) begin
               // Last bit: a held word takes priority over a fresh transfer.
               if (r_hold_full) begin
                  w_sr         = r_hold;
                  w_hold_full  = 1'b0;
                  w_cnt        = CNT_LAST;
                  w_word_start = 1'b1;
               end else if (w_xfer) begin
                  w_sr         = in_data;
                  w_cnt        = CNT_LAST;
                  w_word_start = 1'b1;
               end else begin
                  w_sr    = '0;
                  w_state = IDLE;
               end
            end else begin
               w_sr  = {r_sr[WIDTH-2:0], 1'b0};
               w_cnt = r_cnt - CNT_W'(1);
               if (w_xfer) begin
                  w_hold      = in_data;
                  w_hold_full = 1'b1;
               end
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_sr         <= '0;
         r_cnt        <= '0;
         r_hold       <= '0;
         r_hold_full  <= 1'b0;
         r_x          <= IDLE_BIT;
         r_x_valid    <= 1'b0;
         r_word_start <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_sr         <= w_sr;
         r_cnt        <= w_cnt;
         r_hold       <= w_hold;
         r_hold_full  <= w_hold_full;
         // Outputs are registered from next-state values so x shows the MSB
         // in the cycle right after the loading edge.
         r_x          <= (w_state == SHIFT) ? w_sr[WIDTH-1] : IDLE_BIT;
         r_x_valid    <= (w_state == SHIFT);
         r_word_start <= w_word_start;
      end
   end

   assign in_ready   = ~r_hold_full;
   assign x          = r_x;
   assign x_valid    = r_x_valid;
   assign word_start = r_word_start;
   assign busy       = (r_state == SHIFT) | r_hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: driver queues expected bits per accepted
// word, a negedge monitor pops and compares every serial cycle.
module tb_bit_serializer;

   localparam int   WIDTH    = 8;
   localparam logic IDLE_BIT = 1'b0;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready, x, x_valid, word_start, busy;

   typedef struct packed {
      logic b;
      logic ws;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   run_len = 0;
   int   last_run = 0;
   int   match_cnt = 0;
   logic [2:0] hist = '0;

   bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x          (x),
      .x_valid    (x_valid),
      .word_start (word_start),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Drive a word and wait (bounded) for the handshake; expected bits queued on accept.
   task automatic send(input logic [WIDTH-1:0] w);
      int n = 0;
      @(negedge clk);
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back('{b: w[i], ws: (i == WIDTH - 1)});
      @(posedge clk);
   endtask

   task automatic release_in();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Monitor: every cycle is either a data bit from the queue or an idle bit.
   always @(negedge clk) begin
      if (reset) begin
         hist    = '0;
         run_len = 0;
      end else begin
         hist = {hist[1:0], x};
         if (hist == 3'b101) match_cnt++;
         if (x_valid) begin
            run_len++;
            if (exp_q.size() == 0) begin
               chk("unexpected_bit", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("x_bit", {31'd0, x}, {31'd0, e.b});
               chk("word_start", {31'd0, word_start}, {31'd0, e.ws});
            end
         end else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
            chk("idle_x", {31'd0, x}, {31'd0, IDLE_BIT});
            chk("idle_ws", {31'd0, word_start}, 32'd0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int m0;
      // Reset values, then 20 idle cycles
      #1;
      chk("rst_x", {31'd0, x}, {31'd0, IDLE_BIT});
      chk("rst_xv", {31'd0, x_valid}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m0 = match_cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ready", {31'd0, in_ready}, 32'd1);
         chk("idle_xv", {31'd0, x_valid}, 32'd0);
      end
      chk("idle_match", match_cnt - m0, 0);

      // Single word 1010_0000: latency 1, one 101 match, x_valid drops at k+9
      m0 = match_cnt;
      send(8'b1010_0000);
      release_in();
      chk("lat_xv", {31'd0, x_valid}, 32'd1);
      chk("lat_ws", {31'd0, word_start}, 32'd1);
      chk("lat_x", {31'd0, x}, 32'd1);
      chk("lat_busy", {31'd0, busy}, 32'd1);
      repeat (8) @(negedge clk);
      chk("end_xv", {31'd0, x_valid}, 32'd0);
      chk("end_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("single_match", match_cnt - m0, 1);

      // Three back-to-back words: 24-bit unbroken run, in_ready low while hold full
      send(8'hA5);
      send(8'h5A);
      #1;
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      send(8'hFF);
      release_in();
      repeat (30) @(negedge clk);
      chk("b2b_run", last_run, 24);
      chk("b2b_drain", exp_q.size(), 0);

      // 0x02 then 0x80: "10|1" across the boundary is the only 101
      m0 = match_cnt;
      send(8'h02);
      send(8'h80);
      release_in();
      repeat (22) @(negedge clk);
      chk("boundary_match", match_cnt - m0, 1);

      // Async reset mid-word with hold full
      send(8'hC3);
      send(8'h11);
      release_in();
      @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("arst_x", {31'd0, x}, {31'd0, IDLE_BIT});
      chk("arst_xv", {31'd0, x_valid}, 32'd0);
      chk("arst_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      send(8'h81);
      release_in();
      repeat (12) @(negedge clk);
      chk("post_rst_drain", exp_q.size(), 0);

      // in_valid pulsed while in_ready low: 0xEE must never appear
      send(8'h3C);
      send(8'h99);
      @(negedge clk);
      chk("blocked_ready", {31'd0, in_ready}, 32'd0);
      in_data  = 8'hEE;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (25) @(negedge clk);
      chk("blocked_drain", exp_q.size(), 0);
      chk("blocked_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
